// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display link: receiver FSM states and the
// active-low hex segment table, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic {StSeek1, StSeek2} rx_state_e;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_inv_decode.sv
// Inverse seven-segment decode: maps an active-low segment pattern back to its hex nibble.
module seg7_inv_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       match
);

  always_comb begin
    nibble = '0;
    match  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nibble = 4'(i);
        match  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_demux_rx.sv
// Recovers digit pairs from a multiplexed dual-digit seven-segment drive and presents
// them on a valid/ready interface with sticky error flags.
module seg_demux_rx
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic       anode1,
  input  logic       anode2,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       pair_valid,
  input  logic       pair_ready,
  output logic       bad_pattern,
  output logic       overrun,
  input  logic       clear_err
);

  localparam logic [6:0] SegIdle = 7'h7F;
  localparam logic [7:0] CntMax  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CntHit  = 8'(STABLE_CYCLES - 2);

  logic [6:0] seg_s1, seg_s2;
  logic       an1_s1, an1_s2, an2_s1, an2_s2;
  logic [8:0] sample, sample_q;
  logic [7:0] cnt_q, cnt_d;
  logic       stable_hit;
  logic [3:0] dec_nibble;
  logic       dec_match;

  rx_state_e  state_q, state_d;
  logic [3:0] hold1_q, hold1_d;
  logic       pair_latch, bad_evt;
  logic [3:0] digit1_d, digit2_d;
  logic       pair_valid_d, bad_pattern_d, overrun_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1 <= SegIdle;
      seg_s2 <= SegIdle;
      an1_s1 <= 1'b1;
      an1_s2 <= 1'b1;
      an2_s1 <= 1'b1;
      an2_s2 <= 1'b1;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      an1_s1 <= anode1;
      an1_s2 <= an1_s1;
      an2_s1 <= anode2;
      an2_s2 <= an2_s1;
    end
  end

  assign sample = {an1_s2, an2_s2, seg_s2};

  // Hit fires once per dwell: the counter passes STABLE_CYCLES-2 only on the way up.
  always_comb begin
    stable_hit = (sample == sample_q) && (cnt_q == CntHit);
    if (sample != sample_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  seg7_inv_decode u_dec (
    .seg    (seg_s2),
    .nibble (dec_nibble),
    .match  (dec_match)
  );

  always_comb begin
    state_d    = state_q;
    hold1_d    = hold1_q;
    pair_latch = 1'b0;
    bad_evt    = 1'b0;
    if (stable_hit) begin
      unique case ({an1_s2, an2_s2})
        2'b11: ;
        2'b00: begin
          bad_evt = 1'b1;
          state_d = StSeek1;
        end
        default: begin
          if (!dec_match) begin
            bad_evt = 1'b1;
            state_d = StSeek1;
          end else if (!an1_s2) begin
            hold1_d = dec_nibble;
            state_d = StSeek2;
          end else if (state_q == StSeek2) begin
            pair_latch = 1'b1;
            state_d    = StSeek1;
          end
        end
      endcase
    end
  end

  always_comb begin
    digit1_d     = digit1;
    digit2_d     = digit2;
    pair_valid_d = pair_valid;
    overrun_d    = clear_err ? 1'b0 : overrun;
    bad_pattern_d = bad_evt ? 1'b1 : (clear_err ? 1'b0 : bad_pattern);
    if (pair_latch) begin
      if (!pair_valid || pair_ready) begin
        digit1_d     = hold1_q;
        digit2_d     = dec_nibble;
        pair_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pair_valid && pair_ready) begin
      pair_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q    <= {1'b1, 1'b1, SegIdle};
      cnt_q       <= '0;
      state_q     <= StSeek1;
      hold1_q     <= '0;
      digit1      <= '0;
      digit2      <= '0;
      pair_valid  <= 1'b0;
      bad_pattern <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sample_q    <= sample;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      hold1_q     <= hold1_d;
      digit1      <= digit1_d;
      digit2      <= digit2_d;
      pair_valid  <= pair_valid_d;
      bad_pattern <= bad_pattern_d;
      overrun     <= overrun_d;
    end
  end

endmodule

// File: doc/seg_demux_rx.md
SEG_DEMUX_RX -- requirements
Module: seg_demux_rx

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples needed to accept a digit (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: the single clock for the block.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port seg, input, 7: active-low segments, bit order {g,f,e,d,c,b,a}, from the dual-digit display driver.
REQ-005 SHALL have ports anode1 and anode2, input, 1 each: active-low digit enables; anode1 selects digit 1 and anode2 selects digit 2.
REQ-006 SHALL have port digit1, output, 4: recovered hex value of digit 1.
REQ-007 SHALL have port digit2, output, 4: recovered hex value of digit 2.
REQ-008 SHALL have port pair_valid, output, 1: digit1 and digit2 hold a new captured pair.
REQ-009 SHALL have port pair_ready, input, 1: the consumer accepts the pair.
REQ-010 SHALL have ports bad_pattern and overrun, output, 1 each: sticky error flags.
REQ-011 SHALL have port clear_err, input, 1: synchronous clear of both sticky flags.

Function
REQ-012 SHALL pass seg, anode1 and anode2 through a 2-flop synchronizer; all following rules act on synchronized samples.
REQ-013 SHALL keep a stability counter: cleared when the sample {anode1,anode2,seg} differs from the previous sample, incremented otherwise, saturating at STABLE_CYCLES.
REQ-014 SHALL accept a digit once per dwell, on the cycle the counter first reaches STABLE_CYCLES-1 (the STABLE_CYCLES-th identical sample), only if exactly one anode is low.
REQ-015 SHALL treat both anodes high as blanking: no acceptance, no error.
REQ-016 SHALL treat a stable sample with both anodes low as illegal: set bad_pattern and return to SEEK1.
REQ-017 SHALL decode seg as the exact inverse of the hex 0-F seven-segment table; any non-table pattern on an accepted dwell SHALL set bad_pattern and return to SEEK1.
REQ-018 SHALL implement the FSM SEEK1 -> (digit-1 accept) SEEK2 -> (digit-2 accept) SEEK1. The digit-2 accept SHALL latch the pair.
REQ-019 SHALL, in SEEK1, ignore digit-2 dwells; in SEEK2, replace the held digit 1 with the new value on a further digit-1 accept and remain in SEEK2.
REQ-020 SHALL, when a pair is latched, load digit1 and digit2 and assert pair_valid on the next clock edge.
REQ-021 SHALL hold pair_valid and both digit outputs stable until a cycle with pair_valid and pair_ready both high; pair_valid SHALL fall on the following edge.
REQ-022 SHALL, on a new pair latch while pair_valid is high and pair_ready is low, discard the new pair, keep the old pair and set overrun.
REQ-023 SHALL, on a new pair latch in the same cycle as a handshake, load the new pair and keep pair_valid high.
REQ-024 SHALL, with clear_err and an error event in the same cycle, leave the flag set (set wins).

Reset
REQ-025 SHALL, on reset, asynchronously drive digit1=0, digit2=0, pair_valid=0, bad_pattern=0 and overrun=0, set the FSM to SEEK1, clear the counter, and load the synchronizers with the idle value (anodes high, seg=7'h7F).
REQ-026 SHALL, on reset mid-capture, discard any partial pair, with no pair_valid pulse after reset release.

Structure
REQ-027 SHALL keep the FSM state enum and the 16-entry segment pattern constant table in shared package seg_pkg, which the display driver reuses.
REQ-028 SHALL place the decode in sub-module seg7_inv_decode: combinational, seg[6:0] in, nibble and match out.

Verification
REQ-029 SHALL cover: anode1 low with seg=1111001 for 4 cycles, then anode2 low with seg=0110000 for 4 cycles -> digit1=1, digit2=3, pair_valid high.
REQ-030 SHALL cover: digit 1 seg=1000000 held only 3 cycles -> no accept; held 4 cycles, then digit 2 seg=0001000 -> pair 0/A.
REQ-031 SHALL cover: pair pending with pair_ready=0 and a second pair captured -> first pair retained and overrun=1; clear_err -> overrun=0.
REQ-032 SHALL cover: stable seg=1111111 with anode1 low -> bad_pattern=1, FSM in SEEK1; both anodes low -> bad_pattern=1.
REQ-033 SHALL cover: reset asserted between the digit-1 and digit-2 accepts -> all outputs 0, and the next full sequence 1/3 captures correctly.
REQ-034 SHALL cover: pair_ready held high with continuous capture of 5 pairs -> 5 handshakes, overrun stays 0.
